pe_ws_db: RTL
=============

Name: pe_ws_db

Overview:
- Next-generation weight-stationary systolic processing element for the mini-TPU array.
- Weights are double-buffered: a shadow register loads over a tagged column daisy chain while the active weight keeps computing.
- Adds valid-qualified dataflow, signed/unsigned mode and an overflow flag.
- Optional compile-time saturation.
- Tiles in an R x C grid:
  - activations travel right;
  - partial sums travel down;
  - weights travel down the load chain.

Parameters:
- DATA_WIDTH, 8: activation/weight width.
- ACC_WIDTH, 16: partial-sum width; must be >= DATA_WIDTH.
- TAG_WIDTH, 4: weight-load row-tag width.
- ROW_ID, 0: tag value this PE captures on the load chain; 0..2^TAG_WIDTH-1.
- SIGNED, 1: 1 = two's-complement operands and psum; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_a  in  DATA_WIDTH  activation from the left.
- in_a_valid  in  1  qualifies in_a and in_psum; same cycle, array pre-skewed.
- in_psum  in  ACC_WIDTH  partial sum from above.
- in_swap  in  1  swap pulse; travels right with activations.
- w_in  in  DATA_WIDTH  weight-chain data from above.
- w_in_tag  in  TAG_WIDTH  weight-chain row tag.
- w_in_valid  in  1  weight-chain valid.
- out_a  out  DATA_WIDTH  registered activation to the right.
- out_a_valid  out  1  registered valid to the right.
- out_psum  out  ACC_WIDTH  registered partial sum downward.
- out_psum_valid  out  1  registered valid downward; equals out_a_valid.
- out_swap  out  1  in_swap delayed one cycle.
- w_out, w_out_tag, w_out_valid  out  DATA_WIDTH/TAG_WIDTH/1  weight chain delayed one cycle.
- shadow_full  out  1  shadow holds an unswapped weight.
- active_valid  out  1  active weight has been loaded at least once.
- ovf  out  1  sticky overflow; cleared only by rst.

Behaviour:
- Reset:
  - Clock is clk; reset is asynchronous and active-high on rst.
  - On rst assert: every output, active weight, shadow weight and internal flag go to 0 immediately.
  - Reset mid-load or mid-stream discards all state; no partial completion.
- Weight chain:
  - Every cycle: w_out <= w_in, w_out_tag <= w_in_tag, w_out_valid <= w_in_valid.
  - Forwarding is unconditional, including the captured beat.
  - Capture: if w_in_valid && w_in_tag == ROW_ID, then shadow <= w_in and shadow_full <= 1.
  - Capture while shadow_full = 1 overwrites the shadow.
- Swap:
  - out_swap <= in_swap every cycle.
  - If in_swap && shadow_full: active <= shadow, active_valid <= 1, shadow_full <= 0.
  - If in_swap && !shadow_full: active is unchanged; the swap is still forwarded.
  - Capture and swap in the same cycle: the old shadow moves to active, the new w_in lands in shadow, and shadow_full stays 1.
- MAC:
  - Latency 1 cycle.
  - When in_a_valid = 1:
    - out_a <= in_a;
    - out_a_valid = out_psum_valid <= 1;
    - out_psum <= in_psum + in_a * active.
  - The MAC always uses the active weight held before the edge, so a swap in the same cycle affects only the next beat.
  - When active_valid = 0, the product is forced to 0 and the psum passes through.
  - When in_a_valid = 0: out_a and out_psum hold their values; both valid outputs go to 0.
- Arithmetic:
  - Product width is 2*DATA_WIDTH, sign- or zero-extended per SIGNED.
  - Sum is computed at ACC_WIDTH+1 bits.
  - Overflow = sum outside the ACC_WIDTH range for the current SIGNED mode; it sets ovf, and only on valid beats.
  - Result truncates to ACC_WIDTH, or saturates (see Optional Feature).
- FSM per weight buffer:
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on swap.
  - FULL -> FULL on capture+swap or on overwrite.
  - Exported as shadow_full.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined: on overflow, out_psum clamps to the maximum or minimum of ACC_WIDTH for the current SIGNED mode.
  - Signed: +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1).
  - Unsigned: 2^ACC_WIDTH-1, or 0 on underflow.
  - ovf is still set.
- Undefined: out_psum wraps modulo 2^ACC_WIDTH; ovf behaviour is identical.

Test Plan:
1. Load and swap: ROW_ID=2; send w_in=5 with tag 2, then w_in=9 with tag 1.
   -> shadow_full=1, shadow=5; w_out shows 5 then 9 one cycle later each.
   -> in_swap gives active_valid=1 and shadow_full=0.
2. Basic MAC, SIGNED=1, active=-3: in_a=4, in_psum=100, valid.
   -> next cycle out_psum=88, out_a=4, out_a_valid=1.
   -> following idle cycle: valid=0, out_psum holds 88.
3. Swap timing: active=2, shadow=7; in_swap with in_a=1, in_psum=0; next beat in_a=1, in_psum=0.
   -> out_psum=2, then 7; out_swap pulses one cycle later.
4. Simultaneous capture and swap: shadow=3; swap plus capture of w_in=6.
   -> active=3, shadow=6, shadow_full stays 1.
5. Overflow, SIGNED=1, ACC_WIDTH=16: active=127, in_a=127, in_psum=32000.
   -> with PE_SAT_EN: out_psum=32767.
   -> without PE_SAT_EN: out_psum=-17407.
   -> ovf=1 in both builds; ovf stays 1 after later non-overflowing beats.
6. Async reset mid-stream: assert rst between clock edges during valid traffic.
   -> all outputs 0 immediately, before the next edge.
   -> after release with no new load, active_valid=0 and in_psum=50 passes through as out_psum=50.

Source files
------------

// File: rtl/pe_ws_db_if.sv
// pe_ws_db_if: bundles the dataflow, weight-chain and status signals of one
// weight-stationary PE. The PE connects through the slave modport; whatever
// feeds and observes the PE (neighbours, test harness) uses the master modport.
interface pe_ws_db_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH  = 4
);
  // activation / partial-sum flow
  logic [DATA_WIDTH-1:0] in_a;
  logic                  in_a_valid;
  logic [ACC_WIDTH-1:0]  in_psum;
  logic                  in_swap;
  logic [DATA_WIDTH-1:0] out_a;
  logic                  out_a_valid;
  logic [ACC_WIDTH-1:0]  out_psum;
  logic                  out_psum_valid;
  logic                  out_swap;

  // weight load chain
  logic [DATA_WIDTH-1:0] w_in;
  logic [TAG_WIDTH-1:0]  w_in_tag;
  logic                  w_in_valid;
  logic [DATA_WIDTH-1:0] w_out;
  logic [TAG_WIDTH-1:0]  w_out_tag;
  logic                  w_out_valid;

  // status
  logic                  shadow_full;
  logic                  active_valid;
  logic                  ovf;

  modport master (
    output in_a, in_a_valid, in_psum, in_swap, w_in, w_in_tag, w_in_valid,
    input  out_a, out_a_valid, out_psum, out_psum_valid, out_swap,
    input  w_out, w_out_tag, w_out_valid, shadow_full, active_valid, ovf
  );

  modport slave (
    input  in_a, in_a_valid, in_psum, in_swap, w_in, w_in_tag, w_in_valid,
    output out_a, out_a_valid, out_psum, out_psum_valid, out_swap,
    output w_out, w_out_tag, w_out_valid, shadow_full, active_valid, ovf
  );
endinterface

// File: rtl/pe_ws_db.sv
// pe_ws_db: weight-stationary systolic PE with a double-buffered weight.
// A shadow weight is captured from a tagged daisy chain while the active
// weight keeps feeding the MAC; a swap pulse (travelling with the activations)
// promotes shadow to active. Supports signed/unsigned operands and a sticky
// overflow flag.
// Compile-time option: define PE_SAT_EN to clamp out_psum on overflow instead
// of wrapping modulo 2^ACC_WIDTH.
module pe_ws_db #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned ROW_ID     = 0,
  parameter int unsigned SIGNED     = 1
) (
  input logic        clk,
  input logic        rst,
  pe_ws_db_if.slave  bus
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  // wide enough that the sum of any psum and any product never wraps
  localparam int unsigned SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
  localparam int unsigned EXT_W  = SUM_W - ACC_WIDTH + 1;

  // shadow buffer states
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [DATA_WIDTH-1:0] shadow_w;
  logic [DATA_WIDTH-1:0] active_w;
  logic                  active_v;

  logic                  capture_c;
  logic                  swap_c;

  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;
  logic [SUM_W-1:0]         psum_ext;
  logic [SUM_W-1:0]         prod_ext;
  logic [SUM_W-1:0]         sum;
  logic                     ovf_c;
  logic [ACC_WIDTH-1:0]     sat_val;
  logic [ACC_WIDTH-1:0]     result;

  logic [DATA_WIDTH-1:0] a_q;
  logic                  a_valid_q;
  logic [ACC_WIDTH-1:0]  psum_q;
  logic                  swap_q;
  logic [DATA_WIDTH-1:0] w_q;
  logic [TAG_WIDTH-1:0]  w_tag_q;
  logic                  w_valid_q;
  logic                  ovf_q;

  assign capture_c = bus.w_in_valid && (bus.w_in_tag == TAG_WIDTH'(ROW_ID));
  assign swap_c    = bus.in_swap && (state == ST_FULL);

  // shadow buffer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // shadow buffer next state: a capture always leaves the shadow occupied
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (capture_c) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (swap_c && !capture_c) begin
          state_next = ST_EMPTY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // shadow / active weight storage; swap reads the shadow value before capture overwrites it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_w <= '0;
      active_w <= '0;
      active_v <= 1'b0;
    end else begin
      if (swap_c) begin
        active_w <= shadow_w;
        active_v <= 1'b1;
      end
      if (capture_c) begin
        shadow_w <= bus.w_in;
      end
    end
  end

  // full-width products in both modes; the mode selects which one is used
  always_comb begin
    prod_s = PROD_W'($signed(bus.in_a)) * PROD_W'($signed(active_w));
    prod_u = PROD_W'(bus.in_a) * PROD_W'(active_w);
  end

  // extend operands per mode, add without loss and detect range overflow
  always_comb begin
    psum_ext = '0;
    prod_ext = '0;
    ovf_c    = 1'b0;
    sat_val  = '1;
    if (SIGNED != 0) begin
      psum_ext = SUM_W'($signed(bus.in_psum));
      if (active_v) begin
        prod_ext = SUM_W'(prod_s);
      end
    end else begin
      psum_ext = SUM_W'(bus.in_psum);
      if (active_v) begin
        prod_ext = SUM_W'(prod_u);
      end
    end
    sum = psum_ext + prod_ext;
    if (SIGNED != 0) begin
      ovf_c = (sum[SUM_W-1:ACC_WIDTH-1] != {EXT_W{sum[SUM_W-1]}});
      if (sum[SUM_W-1]) begin
        sat_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        sat_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      // operands are non-negative, so only the upper bound can be exceeded
      ovf_c   = |sum[SUM_W-1:ACC_WIDTH];
      sat_val = '1;
    end
  end

  // truncate, or clamp on overflow when saturation is built in
  always_comb begin
    result = sum[ACC_WIDTH-1:0];
`ifdef PE_SAT_EN
    if (ovf_c) begin
      result = sat_val;
    end
`else
    if (ovf_c && (sat_val == '0)) begin
      result = sum[ACC_WIDTH-1:0];
    end
`endif
  end

  // MAC pipeline stage: data holds on idle beats, valids drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      psum_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (bus.in_a_valid) begin
        a_q       <= bus.in_a;
        a_valid_q <= 1'b1;
        psum_q    <= result;
        if (ovf_c) begin
          ovf_q <= 1'b1;
        end
      end else begin
        a_valid_q <= 1'b0;
      end
    end
  end

  // unconditional one-cycle forwarding of the swap pulse and weight chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_q    <= 1'b0;
      w_q       <= '0;
      w_tag_q   <= '0;
      w_valid_q <= 1'b0;
    end else begin
      swap_q    <= bus.in_swap;
      w_q       <= bus.w_in;
      w_tag_q   <= bus.w_in_tag;
      w_valid_q <= bus.w_in_valid;
    end
  end

  assign bus.out_a          = a_q;
  assign bus.out_a_valid    = a_valid_q;
  assign bus.out_psum       = psum_q;
  assign bus.out_psum_valid = a_valid_q;
  assign bus.out_swap       = swap_q;
  assign bus.w_out          = w_q;
  assign bus.w_out_tag      = w_tag_q;
  assign bus.w_out_valid    = w_valid_q;
  assign bus.shadow_full    = (state == ST_FULL);
  assign bus.active_valid   = active_v;
  assign bus.ovf            = ovf_q;

endmodule
